// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit
//  Description : Configurable-depth instruction memory with a post-reset clear
//                sweep, a sequential program loader and a one-cycle
//                request/response fetch port with fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_addr,
    output logic              o_fetch_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_instr,
    output logic              o_resp_fault,
    input  logic              i_ld_start,
    input  logic [31:0]       i_ld_base,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_ld_ready,
    output logic              o_init_done
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [IW-1:0] c_LAST = IW'(DEPTH - 1);
    localparam logic [IW-1:0] c_ONE  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_clr_ptr;
    logic [IW-1:0]       r_ld_ptr;
    logic                r_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_instr;
    logic                r_resp_fault;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_fetch_acc;
    logic [IW-1:0]       w_fetch_idx;
    logic                w_fetch_fault;
    logic [31:0]         w_fetch_upper;
    logic [IW-1:0]       w_ld_idx;
    logic                w_ld_wr;

    // Fetch decode: word index plus misalignment / out-of-range detection
    always_comb begin
        w_fetch_acc   = i_fetch_req && r_ready;
        w_fetch_idx   = i_fetch_addr[IW+1:2];
        w_fetch_upper = i_fetch_addr >> (IW + 2);
        w_fetch_fault = (i_fetch_addr[1:0] != 2'b00) || (w_fetch_upper != 32'd0);
    end

    // Loader target: a start in the same cycle redirects the write to the new base
    always_comb begin
        w_ld_idx = i_ld_start ? i_ld_base[IW+1:2] : r_ld_ptr;
        w_ld_wr  = (r_state == ST_READY) && i_ld_valid;
    end

    // Control FSM: clear sweep, then ready; also owns loader pointer and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clr_ptr    <= '0;
            r_ld_ptr     <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_instr <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_resp_valid <= 1'b0;
                    if (r_clr_ptr == c_LAST) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + c_ONE;
                    end
                end
                ST_READY: begin
                    r_resp_valid <= w_fetch_acc;
                    if (w_fetch_acc) begin
                        // Array read here sees the pre-edge contents (read-before-write)
                        r_resp_instr <= w_fetch_fault ? NOP_WORD[DATA_W-1:0] : r_mem[w_fetch_idx];
                        r_resp_fault <= w_fetch_fault;
                    end
                    if (i_ld_valid) begin
                        r_ld_ptr <= w_ld_idx + c_ONE;
                    end else if (i_ld_start) begin
                        r_ld_ptr <= w_ld_idx;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: single write port shared by the clear sweep and the loader
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_ld_wr) begin
            r_mem[w_ld_idx] <= i_ld_data;
        end
    end

    assign o_fetch_ready = r_ready;
    assign o_ld_ready    = r_ready;
    assign o_init_done   = r_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_instr  = r_resp_instr;
    assign o_resp_fault  = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_unit
//  Description : Directed self-checking bench for imem_fetch_unit (DEPTH=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_unit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              reset;
    logic              i_fetch_req;
    logic [31:0]       i_fetch_addr;
    logic              o_fetch_ready;
    logic              o_resp_valid;
    logic [DATA_W-1:0] o_resp_instr;
    logic              o_resp_fault;
    logic              i_ld_start;
    logic [31:0]       i_ld_base;
    logic              i_ld_valid;
    logic [DATA_W-1:0] i_ld_data;
    logic              o_ld_ready;
    logic              o_init_done;

    int checks;
    int failures;

    imem_fetch_unit #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NOP_WORD(32'h0000_0013)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_ready(o_fetch_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_instr (o_resp_instr),
        .o_resp_fault (o_resp_fault),
        .i_ld_start   (i_ld_start),
        .i_ld_base    (i_ld_base),
        .i_ld_valid   (i_ld_valid),
        .i_ld_data    (i_ld_data),
        .o_ld_ready   (o_ld_ready),
        .o_init_done  (o_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One loader beat: inputs set on the falling edge, sampled on the next rising edge
    task automatic ld_beat(input logic start, input logic [31:0] base,
                           input logic valid, input logic [31:0] data);
        @(negedge clk);
        i_ld_start = start;
        i_ld_base  = base;
        i_ld_valid = valid;
        i_ld_data  = data;
        @(posedge clk);
        #1;
        i_ld_start = 1'b0;
        i_ld_valid = 1'b0;
    endtask

    // Single fetch followed by a check of the response one cycle later
    task automatic fetch_chk(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_instr, input logic exp_fault);
        @(negedge clk);
        i_fetch_req  = 1'b1;
        i_fetch_addr = addr;
        @(posedge clk);
        #1;
        i_fetch_req = 1'b0;
        check_val({tag, "_valid"}, {31'd0, o_resp_valid}, 32'd1);
        check_val({tag, "_instr"}, o_resp_instr, exp_instr);
        check_val({tag, "_fault"}, {31'd0, o_resp_fault}, {31'd0, exp_fault});
    endtask

    // Wait out the clear sweep, checking ready stays low until edge DEPTH
    task automatic sweep_chk(input string tag);
        int early_hi;
        early_hi = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            if (k < DEPTH && (o_init_done || o_fetch_ready || o_ld_ready)) early_hi++;
        end
        check_val({tag, "_early_ready"}, early_hi, 32'd0);
        check_val({tag, "_init_done"}, {31'd0, o_init_done}, 32'd1);
        check_val({tag, "_fetch_ready"}, {31'd0, o_fetch_ready}, 32'd1);
        check_val({tag, "_ld_ready"}, {31'd0, o_ld_ready}, 32'd1);
    endtask

    logic [31:0] stream_exp [3];

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        i_fetch_req  = 1'b0;
        i_fetch_addr = 32'd0;
        i_ld_start   = 1'b0;
        i_ld_base    = 32'd0;
        i_ld_valid   = 1'b0;
        i_ld_data    = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outputs",
                  {26'd0, o_fetch_ready, o_resp_valid, o_resp_fault, o_ld_ready, o_init_done, 1'b0},
                  32'd0);
        check_val("rst_instr", o_resp_instr, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        sweep_chk("sweep1");

        // Every aligned address reads zero after the sweep, streamed back-to-back
        begin
            int bad;
            bad = 0;
            for (int a = 0; a < DEPTH; a++) begin
                @(negedge clk);
                i_fetch_req  = 1'b1;
                i_fetch_addr = 32'(a * 4);
                @(posedge clk);
                #1;
                if (!o_resp_valid || o_resp_instr !== 32'd0 || o_resp_fault) bad++;
            end
            i_fetch_req = 1'b0;
            check_val("zero_sweep_all", bad, 32'd0);
        end
        fetch_chk("zero_0x80", 32'h80, 32'd0, 1'b0);

        // Program load at 0x10
        ld_beat(1'b1, 32'h10, 1'b0, 32'd0);
        ld_beat(1'b0, 32'd0, 1'b1, 32'h0050_0093);
        ld_beat(1'b0, 32'd0, 1'b1, 32'h0010_0113);
        ld_beat(1'b0, 32'd0, 1'b1, 32'h0020_81B3);

        stream_exp[0] = 32'h0050_0093;
        stream_exp[1] = 32'h0010_0113;
        stream_exp[2] = 32'h0020_81B3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_fetch_req  = 1'b1;
            i_fetch_addr = 32'h10 + 32'(i * 4);
            @(posedge clk);
            #1;
            check_val($sformatf("stream%0d_valid", i), {31'd0, o_resp_valid}, 32'd1);
            check_val($sformatf("stream%0d_instr", i), o_resp_instr, stream_exp[i]);
        end
        @(negedge clk);
        i_fetch_req = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_valid", {31'd0, o_resp_valid}, 32'd0);
        check_val("idle_hold", o_resp_instr, 32'h0020_81B3);

        // Wrap-around load, start combined with the first beat
        ld_beat(1'b1, 32'hF8, 1'b1, 32'hAAAA_0001);
        ld_beat(1'b0, 32'd0, 1'b1, 32'hBBBB_0002);
        ld_beat(1'b0, 32'd0, 1'b1, 32'hCCCC_0003);
        ld_beat(1'b0, 32'd0, 1'b1, 32'hDDDD_0004);
        fetch_chk("wrap_w62", 32'hF8, 32'hAAAA_0001, 1'b0);
        fetch_chk("wrap_w63", 32'hFC, 32'hBBBB_0002, 1'b0);
        fetch_chk("wrap_w0", 32'h00, 32'hCCCC_0003, 1'b0);
        fetch_chk("wrap_w1", 32'h04, 32'hDDDD_0004, 1'b0);

        // Faults
        fetch_chk("fault_misalign", 32'h102, 32'h0000_0013, 1'b1);
        fetch_chk("fault_range", 32'h100, 32'h0000_0013, 1'b1);
        fetch_chk("fault_high", 32'h8000_0010, 32'h0000_0013, 1'b1);
        fetch_chk("nofault_0xfc", 32'hFC, 32'hBBBB_0002, 1'b0);

        // Collision: fetch and load of word 5 on the same edge
        ld_beat(1'b1, 32'h14, 1'b1, 32'h1111_1111);
        ld_beat(1'b1, 32'h14, 1'b0, 32'd0);
        @(negedge clk);
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h14;
        i_ld_valid   = 1'b1;
        i_ld_data    = 32'h2222_2222;
        @(posedge clk);
        #1;
        i_fetch_req = 1'b0;
        i_ld_valid  = 1'b0;
        check_val("coll_old", o_resp_instr, 32'h1111_1111);
        fetch_chk("coll_new", 32'h14, 32'h2222_2222, 1'b0);

        // Reset mid-stream: outputs drop without a clock edge
        @(negedge clk);
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h14;
        @(posedge clk);
        #1;
        check_val("pre_rst_valid", {31'd0, o_resp_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_val("async_rst_valid", {31'd0, o_resp_valid}, 32'd0);
        check_val("async_rst_ready", {31'd0, o_fetch_ready}, 32'd0);
        check_val("async_rst_instr", o_resp_instr, 32'd0);
        i_fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sweep_chk("sweep2");
        fetch_chk("resweep_w5", 32'h14, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
